sseg_scan_mux: RTL and testbench
================================

// Module: sseg_scan_mux
// PURPOSE
//  Parametrised time-multiplexed driver for an N-digit seven-segment display with per-digit decimal point.
//  Built-in refresh prescaler: clk runs at board rate; no pre-divided clock needed.
//  Per-digit enable mask. Frame-done strobe for display-update logic.
//  Sits between the digit encoders (per-digit segment patterns) and the board anode/cathode pins.
// PARAMETERS
//  NUM_DIGITS  4      digits scanned, >=2
//  SEG_W       7      segment bits per digit (dp excluded)
//  PRESCALE    1000   clk cycles per digit slot, >=1
//  ACTIVE_LOW  1      1: an/sseg/decimal active-low pins; 0: active-high
// PORTS
//  clk        in   1                  clock
//  reset      in   1                  synchronous, active-high
//  seg_in     in   NUM_DIGITS*SEG_W   digit d pattern at [d*SEG_W +: SEG_W], 1 = segment lit (logical)
//  dp_in      in   NUM_DIGITS         1 = light decimal point of digit d
//  digit_en   in   NUM_DIGITS         0 = digit d blanked
//  an         out  NUM_DIGITS         anode selects, one-hot active at most
//  sseg       out  SEG_W              segment drive for the selected digit
//  decimal    out  1                  dp drive for the selected digit
//  digit_idx  out  $clog2(NUM_DIGITS) digit slot currently scanned
//  frame_done out  1                  1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  - Reset: prescale cnt=0, digit_idx=0, frame_done=0; an, sseg, decimal all INACTIVE (all 1s if ACTIVE_LOW).
//  - Prescaler: cnt 0..PRESCALE-1, wraps; tick when cnt==PRESCALE-1. PRESCALE=1 -> tick every cycle.
//  - Scan FSM: state = digit_idx. On tick: idx+1; NUM_DIGITS-1 -> 0. No other transitions.
//  - frame_done=1 for the cycle in which idx becomes 0 via wrap. Never asserted by reset.
//  - Output regs update every clk from the current idx. One-cycle latency from idx/input change to pins.
//  - Active slot, digit_en[idx]=1:
//    - an: only bit idx active.
//    - sseg = seg_in slice idx.
//    - decimal = dp_in[idx].
//    - All polarity-mapped via ACTIVE_LOW.
//  - digit_en[idx]=0: an, sseg, decimal all inactive; slot still takes PRESCALE cycles (frame time constant).
//  - Frame period always NUM_DIGITS*PRESCALE cycles.
//  - Input changes mid-slot appear on pins next cycle; no input latching per frame.
//  - reset mid-scan: all state to reset values on that edge; first slot afterwards is digit 0, full length.
//  - Unused idx codes (NUM_DIGITS not pow2) unreachable; treat as blanked if ever decoded.
// CONFIGURATION
//  - Macro SSEG_SCAN_DIM_EN defined: adds input brightness [3:0].
//    - Slot split into 16 equal phases; requires PRESCALE % 16 == 0.
//    - phase = cnt / (PRESCALE/16).
//    - an active only while phase < brightness; sseg/decimal unchanged.
//    - brightness=0: all anodes dark; 15: 15/16 duty.
//    - brightness sampled every cycle.
//  - Macro SSEG_SCAN_DIM_EN undefined: no brightness port; anode active whole slot.
// STRUCTURE
//  - Package sseg_pkg:
//    - SEG_W_DEFAULT=7.
//    - localparam-style polarity helper function pol(bit, active_low).
//    - Segment pattern constants SEG_BLANK, SEG_DASH.
//  - Sub-module scan_prescaler (PRESCALE): owns cnt, emits tick and cnt; reused by other scanned peripherals.
// TESTING
//  - NUM_DIGITS=4, PRESCALE=4, ACTIVE_LOW=1; hold reset 3 cycles -> an=4'b1111, sseg=7'h7F, decimal=1, frame_done=0.
//  - Same config, all digit_en=1 -> an cycles 1110,1101,1011,0111, 4 clks each.
//    - sseg = ~seg_in slice.
//    - frame_done pulses every 16 clks.
//  - dp_in=4'b0100 -> decimal=0 only while an=1011; digit_en=4'b1011 -> slot 2 an=1111, sseg=7'h7F, still 4 clks.
//  - NUM_DIGITS=6, PRESCALE=1 -> digit_idx 0..5,0 every clk.
//    - an walks 6 bits.
//    - frame_done each 6th cycle.
//  - reset asserted at idx=2, cnt=1 -> next cycle idx=0, cnt=0, outputs inactive; digit 0 then lasts full PRESCALE.
//  - SSEG_SCAN_DIM_EN, PRESCALE=32, brightness=4 -> anode active 8 of 32 cycles per slot.
//    - brightness=0: an all inactive.

Source files
------------

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
//   Shared definitions for the seven-segment scan driver and its helpers.
//
//   SEG_W_DEFAULT : segment bits per digit, decimal point excluded (a..g)
//   SEG_BLANK     : logical pattern with every segment dark
//   SEG_DASH      : logical pattern lighting only segment g (bit 6)
//   pol()         : maps a logical "on" bit to a pin level for the chosen
//                   pin polarity (active_low=1 -> on drives 0)
// -----------------------------------------------------------------------------
package sseg_pkg;

  localparam int SEG_W_DEFAULT = 7;

  // Bit order is {g,f,e,d,c,b,a}; 1 = segment lit.
  localparam logic [SEG_W_DEFAULT-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W_DEFAULT-1:0] SEG_DASH  = 7'h40;

  // Logical-to-pin polarity map. An XOR keeps it a single gate per pin.
  function automatic logic pol(input logic b, input logic active_low);
    return b ^ active_low;
  endfunction

endpackage

// File: rtl/sseg_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
//   Free-running divider for scanned peripherals. Counts 0..PRESCALE-1 and
//   wraps; tick is high during the last count of each period so a consumer
//   advances exactly once per PRESCALE clocks. PRESCALE=1 ticks every cycle.
//
//   Parameters
//     PRESCALE : clocks per tick period, >= 1
//     CNT_W    : counter width (derived, exposed so callers can size cnt)
//   Ports
//     clk   in  clock
//     reset in  synchronous, active-high; cnt returns to 0
//     cnt   out current count, 0..PRESCALE-1
//     tick  out high when cnt == PRESCALE-1
// -----------------------------------------------------------------------------
module scan_prescaler
  import sseg_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tick;

  // With PRESCALE=1 LAST is 0, so the counter parks at 0 and ticks every clock.
  assign w_tick = (r_cnt == LAST);

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (w_tick) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt  = r_cnt;
  assign tick = w_tick;

endmodule

// File: rtl/sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// sseg_scan_mux
//   Time-multiplexed driver for an N-digit seven-segment display with a
//   per-digit decimal point. A built-in prescaler sets the slot length so the
//   block runs straight off the board clock. Each slot lights one digit; a
//   disabled digit keeps its slot but stays dark, so the frame period is
//   always NUM_DIGITS*PRESCALE clocks. frame_done pulses for one cycle when
//   the scan wraps back to digit 0.
//
//   Pins are registered from the current slot and the live inputs every
//   clock: one cycle from an index or input change to the pins, no per-frame
//   latching of the inputs.
//
//   Optional build macro SSEG_SCAN_DIM_EN adds a 4-bit brightness input. The
//   slot is cut into 16 equal phases (PRESCALE must be a multiple of 16) and
//   the anode is only driven while phase < brightness; segment and decimal
//   drive are not gated. Without the macro the anode is on for the whole slot.
//
//   Parameters
//     NUM_DIGITS : digits scanned, >= 2
//     SEG_W      : segment bits per digit (dp excluded)
//     PRESCALE   : clocks per digit slot, >= 1
//     ACTIVE_LOW : 1 = an/sseg/decimal pins active-low, 0 = active-high
//   Ports
//     clk        in  clock
//     reset      in  synchronous, active-high
//     seg_in     in  digit d logical pattern at [d*SEG_W +: SEG_W]
//     dp_in      in  1 = light decimal point of digit d
//     digit_en   in  0 = digit d blanked
//     brightness in  (SSEG_SCAN_DIM_EN only) on-phases per slot, 0..15
//     an         out anode selects, at most one active
//     sseg       out segment drive for the scanned digit
//     decimal    out decimal-point drive for the scanned digit
//     digit_idx  out digit slot currently scanned
//     frame_done out one-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = SEG_W_DEFAULT,
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SSEG_SCAN_DIM_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            sseg,
  output logic                        decimal,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int   IDX_W = $clog2(NUM_DIGITS);
  localparam int   CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic OFF   = pol(1'b0, ACTIVE_LOW);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cnt;
  logic             w_tick;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .cnt   (w_cnt),
    .tick  (w_tick)
  );

  // ---------------------------------------------------------------------------
  // Scan FSM: the state is the digit index itself; it only moves on tick.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    w_wrap    = 1'b0;
    if (w_tick) begin
      if (r_idx == LAST_IDX) begin
        w_idx_nxt = '0;
        w_wrap    = 1'b1;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select. The loop only matches real digits, so an index code past
  // NUM_DIGITS-1 (unreachable) falls through to the blanked defaults.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_hit;
  logic                  w_lit;
  logic [SEG_W-1:0]      w_sel_seg;
  logic                  w_sel_dp;

  always_comb begin
    w_hit     = '0;
    w_lit     = 1'b0;
    w_sel_seg = '0;
    w_sel_dp  = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_hit[d]  = 1'b1;
        w_lit     = digit_en[d];
        w_sel_seg = seg_in[d*SEG_W +: SEG_W];
        w_sel_dp  = dp_in[d];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Anode gating
  // ---------------------------------------------------------------------------
  logic w_an_on;

`ifdef SSEG_SCAN_DIM_EN
  // Guarded so an invalid PRESCALE still elaborates; it just won't dim evenly.
  localparam int PHASE_LEN = (PRESCALE >= 16) ? (PRESCALE / 16) : 1;

  logic [3:0] w_phase;

  assign w_phase = 4'(w_cnt / CNT_W'(PHASE_LEN));
  assign w_an_on = w_lit & (w_phase < brightness);
`else
  // Slot position only matters for dimming; the bare build ignores it.
  logic w_unused_cnt;

  assign w_unused_cnt = ^w_cnt;
  assign w_an_on      = w_lit;
`endif

  // ---------------------------------------------------------------------------
  // Pin mapping and output registers
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_an_pin;
  logic [SEG_W-1:0]      w_seg_pin;
  logic                  w_dp_pin;

  always_comb begin
    w_an_pin  = '0;
    w_seg_pin = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_an_pin[d] = pol(w_an_on & w_hit[d], ACTIVE_LOW);
    end
    for (int b = 0; b < SEG_W; b++) begin
      w_seg_pin[b] = pol(w_lit & w_sel_seg[b], ACTIVE_LOW);
    end
    w_dp_pin = pol(w_lit & w_sel_dp, ACTIVE_LOW);
  end

  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]      r_sseg;
  logic                  r_decimal;
  logic                  r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an         <= {NUM_DIGITS{OFF}};
      r_sseg       <= {SEG_W{OFF}};
      r_decimal    <= OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_pin;
      r_sseg       <= w_seg_pin;
      r_decimal    <= w_dp_pin;
      // High in the first cycle of digit 0 after a wrap, never after reset.
      r_frame_done <= w_wrap;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign decimal    = r_decimal;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_mux
//   Two instances share clock and reset: A is 4 digits active-low with a short
//   slot, B is 6 digits (non power of two). Expected pins come from an
//   arithmetic model: with k clocks since reset, slot = (k/P)%N and
//   cnt = k%P; pins one clock later show that slot with the inputs seen then.
// -----------------------------------------------------------------------------
module tb_sseg_scan_mux;

`ifdef SSEG_SCAN_DIM_EN
  localparam int P_A = 32;
  localparam int P_B = 16;
  localparam bit DIM = 1'b1;
`else
  localparam int P_A = 4;
  localparam int P_B = 1;
  localparam bit DIM = 1'b0;
`endif
  localparam int N_A = 4;
  localparam int N_B = 6;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] bri;

  logic [27:0] seg_a;
  logic [3:0]  dp_a, en_a;
  logic [3:0]  an_a;
  logic [6:0]  sseg_a;
  logic        dec_a, fd_a;
  logic [1:0]  idx_a;

  logic [41:0] seg_b;
  logic [5:0]  dp_b, en_b;
  logic [5:0]  an_b;
  logic [6:0]  sseg_b;
  logic        dec_b, fd_b;
  logic [2:0]  idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sseg_scan_mux #(.NUM_DIGITS(N_A), .SEG_W(7), .PRESCALE(P_A), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(rst), .seg_in(seg_a), .dp_in(dp_a), .digit_en(en_a),
`ifdef SSEG_SCAN_DIM_EN
    .brightness(bri),
`endif
    .an(an_a), .sseg(sseg_a), .decimal(dec_a), .digit_idx(idx_a), .frame_done(fd_a)
  );

  sseg_scan_mux #(.NUM_DIGITS(N_B), .SEG_W(7), .PRESCALE(P_B), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(rst), .seg_in(seg_b), .dp_in(dp_b), .digit_en(en_b),
`ifdef SSEG_SCAN_DIM_EN
    .brightness(bri),
`endif
    .an(an_b), .sseg(sseg_b), .decimal(dec_b), .digit_idx(idx_b), .frame_done(fd_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin levels (active-low) for k clocks since reset, with the given inputs.
  function automatic void model(input int n, input int p, input int k,
                                input logic [63:0] seg, input logic [7:0] dp,
                                input logic [7:0] en, input logic [3:0] b,
                                output logic [7:0] an, output logic [6:0] sg,
                                output logic dc);
    int   idx;
    logic lit, on;
    idx = (k / p) % n;
    lit = en[idx];
    on  = lit;
    if (DIM && (((k % p) / (p / 16)) >= int'(b))) on = 1'b0;
    an = on ? ~(8'd1 << idx) : 8'hFF;
    sg = lit ? ~seg[idx*7 +: 7] : 7'h7F;
    dc = ~(lit & dp[idx]);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  bit         armed = 1'b0;
  int         ka, kb;
  logic [7:0] ea_an, eb_an;
  logic [6:0] ea_sg, eb_sg;
  logic       ea_dc, eb_dc, ea_fd, eb_fd;
  int         ea_idx, eb_idx;

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      ka = 0; kb = 0;
      ea_an = 8'hFF; ea_sg = 7'h7F; ea_dc = 1'b1; ea_fd = 1'b0;
      eb_an = 8'hFF; eb_sg = 7'h7F; eb_dc = 1'b1; eb_fd = 1'b0;
    end else if (armed) begin
      model(N_A, P_A, ka, {36'd0, seg_a}, {4'd0, dp_a}, {4'd0, en_a}, bri, ea_an, ea_sg, ea_dc);
      model(N_B, P_B, kb, {22'd0, seg_b}, {2'd0, dp_b}, {2'd0, en_b}, bri, eb_an, eb_sg, eb_dc);
      ka++; kb++;
      ea_fd = (ka % (N_A * P_A)) == 0;
      eb_fd = (kb % (N_B * P_B)) == 0;
    end
    ea_idx = (ka / P_A) % N_A;
    eb_idx = (kb / P_B) % N_B;
    #1;
    if (armed) begin
      chk("a_an",   64'(an_a),   64'(ea_an[3:0]));
      chk("a_sseg", 64'(sseg_a), 64'(ea_sg));
      chk("a_dp",   64'(dec_a),  64'(ea_dc));
      chk("a_idx",  64'(idx_a),  64'(ea_idx));
      chk("a_fd",   64'(fd_a),   64'(ea_fd));
      chk("b_an",   64'(an_b),   64'(eb_an[5:0]));
      chk("b_sseg", 64'(sseg_b), 64'(eb_sg));
      chk("b_dp",   64'(dec_b),  64'(eb_dc));
      chk("b_idx",  64'(idx_b),  64'(eb_idx));
      chk("b_fd",   64'(fd_b),   64'(eb_fd));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed phases with literal expectations, then random traffic
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    rst   = 1'b1;
    bri   = 4'd15;
    seg_a = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    dp_a  = 4'b0100;
    en_a  = 4'b1111;
    seg_b = {$urandom, $urandom};
    dp_b  = 6'b000000;
    en_b  = 6'b111111;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_an",   64'(an_a),   64'h0F);
    chk("rst_sseg", 64'(sseg_a), 64'h7F);
    chk("rst_dp",   64'(dec_a),  64'h1);
    chk("rst_fd",   64'(fd_a),   64'h0);
    chk("rst_an_b", 64'(an_b),   64'h3F);
    @(negedge clk) rst = 1'b0;

    // Full frame with all digits on; dp lit on digit 2 only.
    for (int e = 1; e <= 4 * P_A + 1; e++) begin
      @(posedge clk); #2;
      if (e == 1) begin
        chk("f1_an0",   64'(an_a),   64'b1110);
        chk("f1_seg0",  64'(sseg_a), 64'h40);
        chk("f1_dp0",   64'(dec_a),  64'h1);
      end
      if (e == P_A)         chk("f1_idx1",  64'(idx_a), 64'd1);
      if (e == P_A + 1) begin
        chk("f1_an1",   64'(an_a),   64'b1101);
        chk("f1_seg1",  64'(sseg_a), 64'h79);
      end
      if (e == 2 * P_A + 1) begin
        chk("f1_an2",   64'(an_a),   64'b1011);
        chk("f1_dp2",   64'(dec_a),  64'h0);
      end
      if (e == 3 * P_A + 1) chk("f1_an3",  64'(an_a), 64'b0111);
      if (e == 4 * P_A - 1) chk("f1_fd_lo", 64'(fd_a), 64'h0);
      if (e == 4 * P_A)     chk("f1_fd_hi", 64'(fd_a), 64'h1);
      if (e == 4 * P_A + 1) chk("f1_fd_end", 64'(fd_a), 64'h0);
`ifndef SSEG_SCAN_DIM_EN
      if (e == 5) chk("b_idx5", 64'(idx_b), 64'd5);
      if (e == 5) chk("b_fd5",  64'(fd_b),  64'h0);
      if (e == 6) chk("b_idx6", 64'(idx_b), 64'd0);
      if (e == 6) chk("b_fd6",  64'(fd_b),  64'h1);
      if (e == 6) chk("b_an6",  64'(an_b),  64'b011111);
      if (e == 7) chk("b_fd7",  64'(fd_b),  64'h0);
`endif
    end

    // Reset mid-slot at digit 2, count 1; then digit 2 disabled.
    repeat (2 * P_A) @(posedge clk);
    #2;
    chk("pre_rst_idx", 64'(idx_a), 64'd2);
    @(negedge clk);
    rst  = 1'b1;
    en_a = 4'b1011;
    @(posedge clk); #2;
    chk("mid_rst_idx", 64'(idx_a), 64'd0);
    chk("mid_rst_an",  64'(an_a),  64'h0F);
    chk("mid_rst_fd",  64'(fd_a),  64'h0);
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 4 * P_A + 1; e++) begin
      @(posedge clk); #2;
      if (e == P_A - 1)     chk("d0_full_len", 64'(idx_a), 64'd0);
      if (e == P_A)         chk("d0_end",      64'(idx_a), 64'd1);
      if (e == 2 * P_A + 1) begin
        chk("blank_an",   64'(an_a),   64'h0F);
        chk("blank_seg",  64'(sseg_a), 64'h7F);
        chk("blank_dp",   64'(dec_a),  64'h1);
      end
      if (e == 3 * P_A)     chk("blank_len",  64'(an_a), 64'h0F);
      if (e == 3 * P_A + 1) chk("after_blank", 64'(an_a), 64'b0111);
      if (e == 4 * P_A)     chk("blank_fd",   64'(fd_a), 64'h1);
    end

`ifdef SSEG_SCAN_DIM_EN
    // Dimming: brightness 4 of 16 phases, then fully dark.
    @(negedge clk);
    rst  = 1'b1;
    bri  = 4'd4;
    en_a = 4'b1111;
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int e = 1; e <= P_A; e++) begin
      @(posedge clk); #2;
      if (an_a != 4'hF) cnt++;
    end
    chk("dim4_on_cycles", 64'(cnt), 64'd8);
    @(negedge clk) bri = 4'd0;
    cnt = 0;
    for (int e = 1; e <= P_A; e++) begin
      @(posedge clk); #2;
      if (an_a != 4'hF) cnt++;
    end
    chk("dim0_on_cycles", 64'(cnt), 64'd0);
`endif

    // Random inputs, occasional one-cycle resets; the compare process checks.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) seg_a = 28'($urandom);
      if ($urandom_range(0, 3) == 0) seg_b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) dp_a  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dp_b  = 6'($urandom);
      if ($urandom_range(0, 15) == 0) en_a = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en_b = 6'($urandom);
      if ($urandom_range(0, 31) == 0) bri  = 4'($urandom);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
